fixmath_unit: RTL

FIXMATH_UNIT -- requirements
Module: fixmath_unit

---
 rtl/fixmath_unit_if.sv | 27 ++
 rtl/fixmath_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fixmath_unit_if.sv
// fixmath_unit_if: operand/result handshake bundle for fixmath_unit.
// master drives requests and consumes results; slave is the unit.
interface fixmath_unit_if #(
  parameter int M = 10,
  parameter int N = 10
);
  localparam int W = M + N;

  logic [1:0]          op;
  logic [W-1:0]        operand;
  logic                iValid;
  logic                iReady;
  logic signed [W:0]   result;
  logic                err;
  logic                oValid;
  logic                oReady;

  modport master (
    output op, operand, iValid, oReady,
    input  iReady, result, err, oValid
  );

  modport slave (
    input  op, operand, iValid, oReady,
    output iReady, result, err, oValid
  );
endinterface

// File: rtl/fixmath_unit.sv
// fixmath_unit: sqrt / log2 / log10 / ln of an unsigned Q(M.N) operand.
// Define FIXMATH_SQRT_ROUND_EN for round-to-nearest sqrt (one extra cycle).
module fixmath_unit #(
  parameter int M = 10,
  parameter int N = 10
) (
  input  logic          clock,
  input  logic          reset,
  fixmath_unit_if.slave bus
);
  localparam int W  = M + N;
  localparam int R  = (M + 2 * N + 1) / 2;
`ifdef FIXMATH_SQRT_ROUND_EN
  localparam int SI = R + 1;
`else
  localparam int SI = R;
`endif
  localparam int RW  = 2 * SI;
  localparam int RSH = N + 2 * (SI - R);
  localparam int EW  = $clog2(W + N + 1) + 1;
  localparam int CW  = $clog2(SI + N + 1) + 1;
  localparam int LW  = W + 2;
  localparam int PW  = LW + 18;

  typedef enum logic [2:0] {
    IDLE, SQRT, NORM, SQ, SCALE, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [RW-1:0]        rad_q, rad_d;
  logic [SI+2:0]        rem_q, rem_d;
  logic [SI-1:0]        root_q, root_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [EW-1:0] e_q, e_d;
  logic [N:0]           y_q, y_d;
  logic [N-1:0]         frac_q, frac_d;
  logic signed [W:0]    res_q, res_d;
  logic                 err_q, err_d;
  logic                 ov_q, ov_d;

  logic [SI+2:0]        rem_sh, trial;
  logic [2*N+1:0]       sq;
  logic [N+1:0]         sqn;
  logic signed [LW-1:0] lval;
  logic signed [PW-1:0] lwide, kmul, prod;
  int                   lead;
`ifdef FIXMATH_SQRT_ROUND_EN
  logic [SI-1:0]        rnd;
`endif

  assign bus.iReady = (state_q == IDLE) && !reset;
  assign bus.result = res_q;
  assign bus.err    = err_q;
  assign bus.oValid = ov_q;

  always_comb begin
    lead = 0;
    for (int i = 0; i < W; i++)
      if (rad_q[i]) lead = i;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    y_d     = y_q;
    frac_d  = frac_q;
    res_d   = res_q;
    err_d   = err_q;
    ov_d    = ov_q;

    rem_sh = (SI+3)'({rem_q, rad_q[RW-1 -: 2]});
    trial  = (SI+3)'({root_q, 2'b01});
    sq     = (2*N+2)'(y_q) * (2*N+2)'(y_q);
    sqn    = (N+2)'(sq >> N);
    // frac < 2^N, so OR equals (e<<N)+frac
    lval   = LW'(e_q);
    lval   = (lval <<< N) | LW'(frac_q);
    lwide  = lval;
    kmul   = (op_q == 2'd3) ? PW'(45426) : PW'(19728);
    prod   = lwide * kmul;
`ifdef FIXMATH_SQRT_ROUND_EN
    rnd    = SI'(({1'b0, root_q} + (SI+1)'(1)) >> 1);
`endif

    case (state_q)
      IDLE: begin
        if (bus.iValid) begin
          op_d   = bus.op;
          cnt_d  = '0;
          rem_d  = '0;
          root_d = '0;
          frac_d = '0;
          res_d  = '0;
          err_d  = 1'b0;
          if (bus.op == 2'd0) begin
            rad_d   = RW'(bus.operand) << RSH;
            state_d = SQRT;
          end else begin
            rad_d   = RW'(bus.operand);
            state_d = NORM;
          end
        end
      end
      SQRT: begin
        rad_d = rad_q << 2;
        cnt_d = cnt_q + CW'(1);
        if (rem_sh >= trial) begin
          rem_d  = rem_sh - trial;
          root_d = (root_q << 1) | SI'(1);
        end else begin
          rem_d  = rem_sh;
          root_d = root_q << 1;
        end
        if (cnt_q == CW'(SI - 1)) state_d = SCALE;
      end
      NORM: begin
        if (rad_q[W-1:0] == '0) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = DONE;
        end else begin
          e_d     = EW'(lead - N);
          y_d     = (lead >= N) ?
                    (N+1)'(rad_q[W-1:0] >> (lead - N)) :
                    (N+1)'(rad_q[W-1:0] << (N - lead));
          cnt_d   = '0;
          state_d = SQ;
        end
      end
      SQ: begin
        cnt_d = cnt_q + CW'(1);
        if (sqn[N+1]) begin
          y_d    = sqn[N+1:1];
          frac_d = (frac_q << 1) | N'(1);
        end else begin
          y_d    = sqn[N:0];
          frac_d = frac_q << 1;
        end
        if (cnt_q == CW'(N - 1)) state_d = SCALE;
      end
      SCALE: begin
        state_d = DONE;
        unique case (1'b1)
          (op_q == 2'd0): begin
`ifdef FIXMATH_SQRT_ROUND_EN
            if (rnd[R]) res_d = (W+1)'({R{1'b1}});
            else        res_d = (W+1)'(rnd[R-1:0]);
`else
            res_d = (W+1)'(root_q);
`endif
          end
          (op_q == 2'd1): res_d = (W+1)'(lval);
          (op_q == 2'd2): res_d = (W+1)'(prod >>> 16);
          (op_q == 2'd3): res_d = (W+1)'(prod >>> 16);
        endcase
      end
      DONE: begin
        ov_d = 1'b1;
        if (ov_q && bus.oReady) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      e_q     <= '0;
      y_q     <= '0;
      frac_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      y_q     <= y_d;
      frac_q  <= frac_d;
      res_q   <= res_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
    end
  end
endmodule
